rgmii_tx_framer: RTL and testbench

//  Ethernet transmit framer that sequences the RGMII DDR output stage.

---
 rtl/eth_pkg.sv | 25 ++
 rtl/crc32_d8.sv | 17 +
 rtl/rgmii_tx_framer.sv | 146 ++++++++++++++
 tb/tb_rgmii_tx_framer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet TX constants and the framer state type.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam int unsigned PREAMBLE_LEN    = 7;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  // Shared width of the preamble / FCS / IFG cycle counter
  localparam int unsigned CNT_W           = 16;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational IEEE 802.3 reflected CRC-32 update for one byte.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY_REFL) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/rgmii_tx_framer.sv
// Ethernet TX framer: preamble, SFD, payload, zero pad, FCS and IFG, one byte per clk
// toward the RGMII output stage.
module rgmii_tx_framer
  import eth_pkg::*;
#(
  parameter int unsigned IFG_BYTES   = 12,
  parameter int unsigned MIN_PAYLOAD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       tx_er,
  output logic       busy,
  output logic       underrun
);

  localparam int unsigned PAY_W = 16;

  tx_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [PAY_W-1:0] pay_cnt;
  logic [PAY_W-1:0] pay_inc;
  logic [31:0]      crc;
  logic [31:0]      crc_next;
  logic [31:0]      fcs;
  logic [7:0]       crc_din;
  logic [7:0]       fcs_byte;
  logic             need_pad;

  // state names the slot the next edge emits, so s_ready leads its output cycle by one
  assign s_ready  = (state == SFD) || (state == DATA);
  assign busy     = (state != IDLE);
  assign crc_din  = (state == PAD) ? 8'h00 : s_data;
  assign fcs      = ~crc;
  assign fcs_byte = 8'(fcs >> {cnt[1:0], 3'b000});

  // Saturating payload count; padding is needed while the bumped count is still short
  assign pay_inc  = (pay_cnt < PAY_W'(MIN_PAYLOAD)) ? pay_cnt + PAY_W'(1) : pay_cnt;
  assign need_pad = (pay_inc < PAY_W'(MIN_PAYLOAD));

  crc32_d8 u_crc (
    .crc_in  (crc),
    .d       (crc_din),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pay_cnt  <= '0;
      crc      <= CRC32_INIT;
      tx_data  <= 8'h00;
      tx_en    <= 1'b0;
      tx_er    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      tx_er    <= 1'b0;
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          tx_data <= 8'h00;
          tx_en   <= 1'b0;
          if (s_valid) begin
            state   <= PREAMBLE;
            tx_data <= PREAMBLE_BYTE;
            tx_en   <= 1'b1;
            cnt     <= CNT_W'(1);
            crc     <= CRC32_INIT;
            pay_cnt <= '0;
          end
        end
        PREAMBLE: begin
          tx_en <= 1'b1;
          if (cnt == CNT_W'(PREAMBLE_LEN)) begin
            state   <= SFD;
            tx_data <= SFD_BYTE;
            cnt     <= '0;
          end else begin
            tx_data <= PREAMBLE_BYTE;
            cnt     <= cnt + CNT_W'(1);
          end
        end
        SFD, DATA: begin
          tx_en <= 1'b1;
          if (s_valid) begin
            tx_data <= s_data;
            crc     <= crc_next;
            pay_cnt <= pay_inc;
            if (s_last) state <= need_pad ? PAD : FCS;
            else        state <= DATA;
          end else begin
            // Source starved mid-frame: mark the abort and skip the FCS
            tx_data  <= 8'h00;
            tx_er    <= 1'b1;
            underrun <= 1'b1;
            state    <= IFG;
            cnt      <= '0;
          end
        end
        PAD: begin
          tx_en   <= 1'b1;
          tx_data <= 8'h00;
          crc     <= crc_next;
          pay_cnt <= pay_inc;
          if (!need_pad) begin
            state <= FCS;
            cnt   <= '0;
          end
        end
        FCS: begin
          tx_en   <= 1'b1;
          tx_data <= fcs_byte;
          if (cnt[1:0] == 2'd3) begin
            state <= IFG;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        IFG: begin
          // IFG_BYTES idle slots, plus the IDLE slot before the next preamble
          tx_en   <= 1'b0;
          tx_data <= 8'h00;
          if (cnt == CNT_W'(IFG_BYTES)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          tx_en   <= 1'b0;
          tx_data <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Self-checking bench for rgmii_tx_framer: vector table on an unpadded instance,
// directed sequences and a frame scoreboard on a default instance.
module tb_rgmii_tx_framer;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic       rst;
  logic [7:0] s_data;
  logic       s_valid, s_last, s_ready;
  logic [7:0] tx_data;
  logic       tx_en, tx_er, busy, underrun;

  logic [7:0] np_data;
  logic       np_valid, np_last, np_ready;
  logic [7:0] np_tx_data;
  logic       np_tx_en, np_tx_er, np_busy, np_underrun;

  rgmii_tx_framer dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .tx_data(tx_data), .tx_en(tx_en), .tx_er(tx_er),
    .busy(busy), .underrun(underrun)
  );

  rgmii_tx_framer #(.IFG_BYTES(12), .MIN_PAYLOAD(0)) dut_np (
    .clk(clk), .rst(rst), .s_data(np_data), .s_valid(np_valid), .s_last(np_last),
    .s_ready(np_ready), .tx_data(np_tx_data), .tx_en(np_tx_en), .tx_er(np_tx_er),
    .busy(np_busy), .underrun(np_underrun)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h000000, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Frame monitor on the default instance: flat byte log plus per-frame records
  logic [7:0] log_q[$];
  int fstart[$];
  int flen[$];
  int fgap[$];
  int cur_len  = 0;
  int gap_len  = 0;
  int er_total = 0;
  int er_alone = 0;

  always @(negedge clk) begin
    if (tx_en) begin
      if (cur_len == 0) begin
        fstart.push_back(log_q.size());
        fgap.push_back(gap_len);
      end
      log_q.push_back(tx_data);
      cur_len++;
      gap_len = 0;
    end else begin
      if (cur_len != 0) begin
        flen.push_back(cur_len);
        cur_len = 0;
      end
      gap_len++;
    end
    if (tx_er) er_total++;
    if (tx_er && !tx_en) er_alone++;
    if (np_tx_er && !np_tx_en) er_alone++;
  end

  logic [7:0] pay[0:1599];

  // Streams pay[0..n-1]; stops early after stop_after accepted bytes
  task automatic send_payload(input int n, input int stop_after, input bit keep_valid, output bit ok);
    int idx;
    int guard;
    bit acc;
    idx = 0; guard = 0; ok = 1'b1;
    s_valid = 1'b1; s_data = pay[0]; s_last = (n == 1);
    while (idx < n && idx < stop_after) begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < n) begin s_data = pay[idx]; s_last = (idx == n - 1); end
      end
      guard++;
      if (guard > 4000) begin ok = 1'b0; break; end
    end
    if (!keep_valid) begin s_valid = 1'b0; s_last = 1'b0; end
  endtask

  task automatic wait_frames(input int target, input string name, output bit ok);
    int g;
    g = 0;
    while (flen.size() < target && g < 20000) begin @(posedge clk); g++; end
    ok = (flen.size() >= target);
    check({name, " frame done"}, 64'(ok), 64'd1);
  endtask

  task automatic check_frame(input string name, input int fi, input int n_pay);
    int exp_len, s, bad;
    logic [31:0] c;
    exp_len = 8 + ((n_pay < 60) ? 60 : n_pay) + 4;
    s = fstart[fi];
    check({name, " length"}, 64'(flen[fi]), 64'(exp_len));
    bad = 0;
    for (int i = 0; i < 7; i++) if (log_q[s + i] !== 8'h55) bad++;
    if (log_q[s + 7] !== 8'hD5) bad++;
    check({name, " preamble"}, 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < n_pay; i++) if (log_q[s + 8 + i] !== pay[i]) bad++;
    for (int i = n_pay; i < 60; i++) if (log_q[s + 8 + i] !== 8'h00) bad++;
    check({name, " payload"}, 64'(bad), 64'd0);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < flen[fi]; i++) c = crc_upd(c, log_q[s + i]);
    check({name, " residue"}, 64'(c), 64'h00000000DEBB20E3);
  endtask

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic       lst;
    logic [7:0] e_data;
    logic       e_en;
    logic       e_er;
    logic       e_rdy;
  } vec_t;

  vec_t vt[0:22];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int base, hi, ers, n;
    logic [31:0] c;
    logic [7:0] fcs_tbl[0:3];
    int lens[0:7];

    fcs_tbl[0] = 8'h26; fcs_tbl[1] = 8'h39; fcs_tbl[2] = 8'hF4; fcs_tbl[3] = 8'hCB;
    for (int i = 0; i <= 22; i++) vt[i] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i <= 7; i++) begin vt[i].vld = 1'b1; vt[i].dat = 8'h31; end
    for (int i = 1; i <= 7; i++) begin vt[i].e_data = 8'h55; vt[i].e_en = 1'b1; end
    vt[8] = '{1'b1, 8'h31, 1'b0, 8'hD5, 1'b1, 1'b0, 1'b1};
    for (int i = 9; i <= 16; i++)
      vt[i] = '{1'b1, 8'(32'h31 + i - 8), (i == 16), 8'(32'h31 + i - 9), 1'b1, 1'b0, 1'b1};
    vt[17].e_data = 8'h39; vt[17].e_en = 1'b1;
    for (int i = 0; i < 4; i++) begin vt[18 + i].e_data = fcs_tbl[i]; vt[18 + i].e_en = 1'b1; end

    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    np_valid = 1'b0; np_data = 8'h00; np_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 64'({tx_data, tx_en, tx_er, s_ready, busy, underrun}), 64'd0);
    check("reset outputs np", 64'({np_tx_data, np_tx_en, np_tx_er, np_ready, np_busy, np_underrun}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // "123456789" with padding disabled: cycle-exact table
    for (int i = 0; i <= 22; i++) begin
      np_valid = vt[i].vld; np_data = vt[i].dat; np_last = vt[i].lst;
      @(negedge clk);
      check($sformatf("np row %0d", i),
            64'({np_tx_data, np_tx_en, np_tx_er, np_ready}),
            64'({vt[i].e_data, vt[i].e_en, vt[i].e_er, vt[i].e_rdy}));
      @(posedge clk); #1;
    end
    np_valid = 1'b0; np_last = 1'b0;

    // One-byte frame padded to minimum
    base = flen.size();
    pay[0] = 8'hAB;
    send_payload(1, 1, 1'b0, ok);
    check("1-byte accept", 64'(ok), 64'd1);
    wait_frames(base + 1, "1-byte", ok);
    if (ok) check_frame("1-byte", base, 1);

    // Two back-to-back 64-byte frames with s_valid never dropping
    base = flen.size();
    for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
    send_payload(64, 64, 1'b1, ok);
    send_payload(64, 64, 1'b0, ok);
    wait_frames(base + 2, "b2b", ok);
    if (ok) begin
      check_frame("b2b first", base, 64);
      check_frame("b2b second", base + 1, 64);
      check("b2b gap", 64'(fgap[base + 1]), 64'd13);
    end

    // Underrun after 10 of 100 bytes
    for (int i = 0; i < 100; i++) pay[i] = 8'($urandom);
    send_payload(100, 10, 1'b0, ok);
    @(negedge clk);
    check("starve cycle", 64'({s_ready, underrun, tx_er}), 64'({1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    check("underrun marker", 64'({tx_en, tx_er, underrun, tx_data}), 64'({1'b1, 1'b1, 1'b1, 8'h00}));
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tx_en || underrun) hi++;
    end
    check("underrun ifg idle", 64'(hi), 64'd0);

    // Reset during the third FCS byte, then immediate restart
    base = flen.size();
    pay[0] = 8'hAB;
    send_payload(1, 1, 1'b0, ok);
    repeat (62) @(posedge clk);
    #1;
    c = crc_upd(32'hFFFFFFFF, 8'hAB);
    for (int i = 0; i < 59; i++) c = crc_upd(c, 8'h00);
    c = ~c;
    @(negedge clk);
    check("third fcs byte", 64'({tx_en, tx_data}), 64'({1'b1, c[23:16]}));
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h11; s_last = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset abort", 64'({tx_en, s_ready, busy, tx_er, underrun, tx_data}), 64'd0);
    @(negedge clk);
    check("restart no ifg", 64'({tx_en, tx_data}), 64'({1'b1, 8'h55}));
    @(posedge clk); #1;
    pay[0] = 8'h11;
    send_payload(1, 1, 1'b0, ok);
    wait_frames(base + 2, "post-reset", ok);
    if (ok) check_frame("post-reset", base + 1, 1);

    // Random lengths with idle and preamble-time gaps
    lens[0] = 1; lens[1] = 59; lens[2] = 60; lens[3] = 61; lens[4] = 1518;
    for (int k = 5; k < 8; k++) lens[k] = int'($urandom_range(1, 1518));
    ers = er_total;
    for (int k = 0; k < 8; k++) begin
      n = lens[k];
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      base = flen.size();
      hi = 0;
      do begin @(negedge clk); hi++; end while (busy && hi < 100);
      if (k % 2 == 1) begin
        s_valid = 1'b1; s_data = pay[0]; s_last = 1'b0;
        @(posedge clk); #1 s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end else begin
        repeat ($urandom_range(0, 20)) @(posedge clk);
        #1;
      end
      send_payload(n, n, 1'b0, ok);
      wait_frames(base + 1, $sformatf("rand%0d", k), ok);
      if (ok) check_frame($sformatf("rand%0d len%0d", k, n), base, n);
    end
    check("rand tx_er", 64'(er_total - ers), 64'd0);
    check("tx_er without tx_en", 64'(er_alone), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
